// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared definitions for the decoder scan sequencer: FSM encoding and first scan codes.
package decoder_scan_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b01,
    ST_RUN  = 2'b10
  } state_t;

  localparam logic [2:0] SEL_FIRST_UP = 3'd0;
  localparam logic [2:0] SEL_FIRST_DN = 3'd7;

  // Last code of a pass in the given direction.
  function automatic logic is_terminal(input logic [2:0] sel, input logic dir);
    return dir ? (sel == SEL_FIRST_UP) : (sel == SEL_FIRST_DN);
  endfunction

endpackage

// File: rtl/decoder_scan_sequencer_dwell.sv
// Dwell counter: counts 0..limit while enabled and flags the cycle in which limit is reached.
module dwell_counter #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               enable,
  input  logic [DWELL_W-1:0] limit,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  // Compare before increment, so limit = all-ones never overflows.
  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == limit) begin
        cnt_d  = '0;
        expire = 1'b1;
      end else begin
        cnt_d = cnt_q + {{(DWELL_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer driving a 3-to-8 decoder: steps sel through all codes with a programmable dwell.
module decoder_scan_sequencer
  import decoder_scan_sequencer_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               step,
  output logic               done
);

  state_t             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               step_q, step_d;
  logic               done_q, done_d;
  logic               mode_q, mode_d;
  logic               dir_q, dir_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               cnt_clear_s, cnt_enable_s, expire_s;

  assign cnt_enable_s = (state_q == ST_RUN);
  assign cnt_clear_s  = (state_q != ST_RUN) || stop;

  dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cnt_clear_s),
    .enable (cnt_enable_s),
    .limit  (dwell_q),
    .expire (expire_s)
  );

  // Next-state, index stepping and status pulses.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    mode_d  = mode_q;
    dir_d   = dir_q;
    dwell_d = dwell_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          mode_d  = mode;
          dir_d   = dir;
          dwell_d = dwell;
          sel_d   = dir ? SEL_FIRST_DN : SEL_FIRST_UP;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          step_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (expire_s) begin
          if (is_terminal(sel_q, dir_q) && !mode_q) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            // Modulo-8 arithmetic provides the continuous-mode wrap for free.
            sel_d  = dir_q ? (sel_q - 3'd1) : (sel_q + 3'd1);
            step_d = 1'b1;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 3'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
      dir_q   <= 1'b0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      step_q  <= step_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      dwell_q <= dwell_d;
    end
  end

  assign sel       = sel_q;
  assign sel_valid = valid_q;
  assign busy      = busy_q;
  assign step      = step_q;
  assign done      = done_q;

endmodule
